// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed multiply (radix-2 Booth) / restoring divide producing HI/LO.
// Optional macro MULT_DIV_UNSIGNED_EN adds unsigned_op for MULTU/DIVU semantics.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
`ifdef MULT_DIV_UNSIGNED_EN
   input  logic             unsigned_op,
`endif
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;
   state_t st, nxt;
   logic [WIDTH:0]   acc, m, sum, bacc, sh, dacc;
   logic [WIDTH-1:0] q, bq, dq, a_mag, b_mag;
   logic [CW-1:0]    cnt;
   logic             q1, corr, neg_q, neg_r, dz, uns, ge, last;
`ifdef MULT_DIV_UNSIGNED_EN
   assign uns = unsigned_op;
`else
   assign uns = 1'b0;
`endif
   assign last  = cnt == CW'(WIDTH - 1);
   assign a_mag = (~uns & a[WIDTH-1]) ? -a : a;
   assign b_mag = (~uns & b[WIDTH-1]) ? -b : b;
   // Booth step: add/subtract multiplicand by {q0,q-1}, then arithmetic shift right
   always_comb begin
      sum  = (q[0] & ~q1) ? acc - m : (~q[0] & q1) ? acc + m : acc;
      bacc = {sum[WIDTH], sum[WIDTH:1]};
      bq   = {sum[0], q[WIDTH-1:1]};
   end
   // Restoring step: shift in next dividend bit, subtract divisor if it fits
   always_comb begin
      sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
      ge   = sh >= m;
      dacc = ge ? sh - m : sh;
      dq   = {q[WIDTH-2:0], ge};
   end
   // State register
   always_ff @(posedge clk or posedge reset)
      if (reset) st <= IDLE;
      else st <= nxt;
   // Next-state logic; multiply wins when both starts are high
   always_comb begin
      nxt = st;
      if (st == IDLE) nxt = start_mult ? MULT : start_div ? ((b == '0) ? FIN : DIV) : IDLE;
      else if (st == MULT || st == DIV) nxt = last ? FIN : st;
      else nxt = IDLE;
   end
   // Status outputs decoded from state
   always_comb begin
      busy     = (st == MULT) || (st == DIV);
      done     = st == FIN;
      div_zero = (st == FIN) && dz;
   end
   // Datapath: operand capture, iteration, and HI/LO write on completion
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         acc <= '0; m <= '0; q <= '0; q1 <= 1'b0; cnt <= '0;
         corr <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
         hi <= '0; lo <= '0;
      end else begin
         case (st)
            IDLE:
               if (start_mult) begin
                  acc <= '0; q <= b; q1 <= 1'b0; cnt <= '0; dz <= 1'b0;
                  m <= {~uns & a[WIDTH-1], a};
                  corr <= uns & b[WIDTH-1];
               end else if (start_div) begin
                  acc <= '0; q <= a_mag; cnt <= '0; dz <= b == '0;
                  m <= {1'b0, b_mag};
                  neg_q <= ~uns & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r <= ~uns & a[WIDTH-1];
               end
            MULT: begin
               acc <= bacc; q <= bq; q1 <= q[0]; cnt <= cnt + 1'b1;
               if (last) begin
                  hi <= bacc[WIDTH-1:0] + (corr ? m[WIDTH-1:0] : '0);
                  lo <= bq;
               end
            end
            DIV: begin
               acc <= dacc; q <= dq; cnt <= cnt + 1'b1;
               if (last) begin
                  lo <= neg_q ? -dq : dq;
                  hi <= neg_r ? -dacc[WIDTH-1:0] : dacc[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table plus hand sequences for reset, div-by-zero and start priority.
module tb_mult_div_unit;
   logic clk = 0, reset = 1, start_mult = 0, start_div = 0;
   logic [31:0] a = 0, b = 0, hi, lo;
   logic busy, done, div_zero;
`ifdef MULT_DIV_UNSIGNED_EN
   logic unsigned_op = 0;
`endif
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset),
`ifdef MULT_DIV_UNSIGNED_EN
      .unsigned_op(unsigned_op),
`endif
      .start_mult(start_mult), .start_div(start_div), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   typedef struct {
      bit          dv;
      logic [31:0] a, b, eh, el;
   } vec_t;
   vec_t v[8];

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   task automatic do_op(input string n, input bit sm, input bit sd, input bit uo,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit edz, input int elat);
      int lat, bc;
      logic [31:0] h, l;
      logic z, bz, d2;
      @(negedge clk);
      start_mult = sm; start_div = sd; a = av; b = bv;
`ifdef MULT_DIV_UNSIGNED_EN
      unsigned_op = uo;
`endif
      @(posedge clk); #1;
      start_mult = 0; start_div = 0; a = $urandom; b = $urandom;
      lat = 0; bc = 0;
      @(negedge clk);
      while (!done && lat < 100) begin
         bc += int'(busy);
         @(negedge clk);
         lat++;
      end
      h = hi; l = lo; z = div_zero; bz = busy;
      @(negedge clk);
      d2 = done;
      chk({n, " latency"}, lat, elat);
      chk({n, " busy_cycles"}, bc, elat);
      chk({n, " hi"}, h, eh);
      chk({n, " lo"}, l, el);
      chk({n, " div_zero"}, {31'b0, z}, {31'b0, edz});
      chk({n, " busy_at_done"}, {31'b0, bz}, 0);
      chk({n, " done_pulse_len"}, {31'b0, d2}, 0);
   endtask

   initial begin
      int nd;
      logic [31:0] h, l;
      v[0] = '{0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      v[1] = '{0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      v[2] = '{1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      v[3] = '{1, 32'd100,      32'd7,        32'd2,        32'd14};
      v[4] = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      v[5] = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
      v[6] = '{1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      v[7] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

      repeat (3) @(posedge clk);
      @(negedge clk); reset = 0;
      @(negedge clk);
      chk("reset hi", hi, 0);
      chk("reset lo", lo, 0);
      chk("reset busy", {31'b0, busy}, 0);
      chk("reset done", {31'b0, done}, 0);
      chk("reset div_zero", {31'b0, div_zero}, 0);

      for (int i = 0; i < 8; i++)
         do_op($sformatf("vec%0d", i), !v[i].dv, v[i].dv, 0, v[i].a, v[i].b, v[i].eh, v[i].el, 0, 32);

      do_op("pre_dz", 1, 0, 0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 32);
      do_op("div_zero", 0, 1, 0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, 0);

      @(negedge clk);
      start_mult = 1; start_div = 1; a = 6; b = 7;
      @(posedge clk); #1;
      start_mult = 0; start_div = 0;
      nd = 0; h = 0; l = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start_div = (k == 5);
         start_mult = 0;
         if (done) begin
            nd++; h = hi; l = lo;
            start_mult = 1;
         end
      end
      start_div = 0;
      chk("both_starts done_count", nd, 1);
      chk("both_starts hi", h, 0);
      chk("both_starts lo", l, 42);
      chk("both_starts idle_after", {31'b0, busy}, 0);

      @(negedge clk);
      start_mult = 1; a = 6; b = 7;
      @(posedge clk); #1;
      start_mult = 0;
      repeat (9) @(posedge clk);
      @(negedge clk); reset = 1; #1;
      chk("abort hi", hi, 0);
      chk("abort lo", lo, 0);
      chk("abort busy", {31'b0, busy}, 0);
      @(negedge clk); reset = 0;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         nd += int'(done);
      end
      chk("abort no_done", nd, 0);
      chk("abort lo_held", lo, 0);

`ifdef MULT_DIV_UNSIGNED_EN
      do_op("multu", 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 32);
      do_op("divu", 0, 1, 1, 32'hFFFFFFFF, 32'd2, 32'd1, 32'h7FFFFFFF, 0, 32);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
